fwd_scoreboard_unit: RTL

Parametrised forwarding and hazard unit for the ARM pipeline. It keeps its own shift register of in-flight writeback destinations for the stages after EX, so the pipeline only presents the instruction currently issuing in EX. Each cycle it produces a forwarding select per EX source operand and a load-use stall request. It replaces per-stage destination compares wired in from MEM/WB and scales to deeper pipelines and more source ports.

---
 rtl/fwd_scoreboard_unit_if.sv | 33 +++
 rtl/fwd_scoreboard_unit.sv | 109 ++++++++++
 2 files changed

// File: rtl/fwd_scoreboard_unit_if.sv
// EX-stage issue bundle and forwarding results for fwd_scoreboard_unit.
// FWD_STATS_EN adds the stallCount/fwdCount statistics outputs.
interface fwd_scoreboard_unit_if #(
  parameter int REG_W     = 4,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH+1)
);
  logic                     exValid;
  logic                     exWbEn;
  logic                     exIsLoad;
  logic [REG_W-1:0]         exDest;
  logic [NUM_SRC*REG_W-1:0] src;
  logic [NUM_SRC-1:0]       srcUsed;
  logic                     flush;
  logic                     freeze;
  logic [NUM_SRC*SEL_W-1:0] sel;
  logic                     stall;
`ifdef FWD_STATS_EN
  logic [15:0]              stallCount;
  logic [15:0]              fwdCount;

  modport master (output exValid, exWbEn, exIsLoad, exDest, src, srcUsed, flush, freeze,
                  input  sel, stall, stallCount, fwdCount);
  modport slave  (input  exValid, exWbEn, exIsLoad, exDest, src, srcUsed, flush, freeze,
                  output sel, stall, stallCount, fwdCount);
`else
  modport master (output exValid, exWbEn, exIsLoad, exDest, src, srcUsed, flush, freeze,
                  input  sel, stall);
  modport slave  (input  exValid, exWbEn, exIsLoad, exDest, src, srcUsed, flush, freeze,
                  output sel, stall);
`endif
endinterface

// File: rtl/fwd_scoreboard_unit.sv
// Forwarding/load-use hazard unit with its own post-EX destination shift register.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_src_lane #(
  parameter int REG_W     = 4,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = 2
) (
  input  logic [FWD_DEPTH-1:0]            i_stg_act,
  input  logic [FWD_DEPTH-1:0][REG_W-1:0] i_stg_dest,
  input  logic                            i_ld1,
  input  logic [REG_W-1:0]                i_src,
  input  logic                            i_used,
  output logic [SEL_W-1:0]                o_sel,
  output logic                            o_haz
);
  logic [FWD_DEPTH-1:0] w_cand;

  always_comb begin
    o_sel = '0;
    for (int k = 0; k < FWD_DEPTH; k++)
      w_cand[k] = i_used & i_stg_act[k] & (i_stg_dest[k] == i_src);
    // Scan oldest to youngest so the youngest candidate is the last to write
    for (int k = FWD_DEPTH-1; k >= 0; k--)
      if (w_cand[k]) o_sel = SEL_W'(k+1);
    o_haz = w_cand[0] & i_ld1;
  end
endmodule

module fwd_scoreboard_unit #(
  parameter int REG_W     = 4,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstN,
  fwd_scoreboard_unit_if.slave  bus
);
  localparam int SEL_W = $clog2(FWD_DEPTH+1);

  typedef struct packed {
    logic             vld;
    logic             wb;
    logic             ld;
    logic [REG_W-1:0] dest;
  } stg_t;

  stg_t                            r_stg [FWD_DEPTH];
  logic [FWD_DEPTH-1:0]            w_act;
  logic [FWD_DEPTH-1:0][REG_W-1:0] w_dest;
  logic [NUM_SRC-1:0][SEL_W-1:0]   w_sel;
  logic [NUM_SRC-1:0]              w_haz;
  logic                            w_stall;
  logic                            w_issue;

  always_comb begin
    for (int k = 0; k < FWD_DEPTH; k++) begin
      w_act[k]  = r_stg[k].vld & r_stg[k].wb;
      w_dest[k] = r_stg[k].dest;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_src_lane #(.REG_W(REG_W), .FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_lane (
      .i_stg_act  (w_act),
      .i_stg_dest (w_dest),
      .i_ld1      (r_stg[0].ld),
      .i_src      (bus.src[i*REG_W +: REG_W]),
      .i_used     (bus.srcUsed[i]),
      .o_sel      (w_sel[i]),
      .o_haz      (w_haz[i])
    );
  end

  assign w_stall   = bus.exValid & ~bus.flush & (|w_haz);
  assign w_issue   = bus.exValid & ~w_stall & ~bus.flush;
  assign bus.sel   = w_sel;
  assign bus.stall = w_stall;

  // Stage 1 is index 0; stall and flush both turn the entering slot into a bubble
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int k = 0; k < FWD_DEPTH; k++) r_stg[k] <= '0;
    end else if (!bus.freeze) begin
      r_stg[0] <= w_issue ? stg_t'{1'b1, bus.exWbEn, bus.exIsLoad, bus.exDest} : '0;
      for (int k = 1; k < FWD_DEPTH; k++) r_stg[k] <= r_stg[k-1];
    end
  end

`ifdef FWD_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_fwd_cnt;
  logic        w_fwd_any;

  assign w_fwd_any = |w_sel;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (!bus.freeze) begin
      if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_issue && w_fwd_any && r_fwd_cnt != 16'hFFFF) r_fwd_cnt <= r_fwd_cnt + 16'd1;
    end
  end

  assign bus.stallCount = r_stall_cnt;
  assign bus.fwdCount   = r_fwd_cnt;
`endif
endmodule
